// File: rtl/fetch_unit.sv
// fetch_unit: Y86-64 fetch stage with F and D pipeline registers.
// Define FETCH_PERF_EN to add the perf_fetched/perf_bubbles counters.
module fetch_unit #(
  parameter int PC_W = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_stall,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic [3:0]      M_icode,
  input  logic            M_cnd,
  input  logic [PC_W-1:0] M_valA,
  input  logic [3:0]      W_icode,
  input  logic [PC_W-1:0] W_valM,
  output logic [PC_W-1:0] imem_addr,
  input  logic [79:0]     imem_bytes,
  input  logic            imem_error,
  output logic [PC_W-1:0] f_predPC,
  output logic [1:0]      D_stat,
  output logic [3:0]      D_icode,
  output logic [3:0]      D_ifun,
  output logic [3:0]      D_rA,
  output logic [3:0]      D_rB,
  output logic [PC_W-1:0] D_valC,
  output logic [PC_W-1:0] D_valP
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);
  logic [PC_W-1:0] F_predPC, f_pc, valC, valP;
  logic [3:0]      icode, ifun, rA, rB;
  logic [1:0]      stat;
  logic [63:0]     c64;
  logic            need_regids, need_valC, instr_valid, load_d;
  assign f_pc = (M_icode == 4'h7 && !M_cnd) ? M_valA : (W_icode == 4'h9) ? W_valM : F_predPC;
  assign imem_addr = f_pc;
  assign icode = imem_error ? 4'h1 : imem_bytes[7:4];
  assign ifun = imem_error ? 4'h0 : imem_bytes[3:0];
  assign instr_valid = icode <= 4'hB;
  assign need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  assign need_valC = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  assign rA = need_regids ? imem_bytes[15:12] : RNONE;
  assign rB = need_regids ? imem_bytes[11:8] : RNONE;
  assign c64 = need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
  assign valC = need_valC ? PC_W'(c64) : '0;
  assign valP = f_pc + PC_W'(1) + PC_W'(need_regids) + (need_valC ? PC_W'(8) : '0);
  assign f_predPC = (icode == 4'h7 || icode == 4'h8) ? valC : valP;
  assign stat = imem_error ? 2'd2 : !instr_valid ? 2'd3 : (icode == 4'h0) ? 2'd1 : 2'd0;
  assign load_d = !rst && !D_stall && !D_bubble;
  always_ff @(posedge clk)
    if (rst) F_predPC <= RESET_PC;
    else if (!F_stall) F_predPC <= f_predPC;
  // Stall outranks bubble; reset always forces a bubble.
  always_ff @(posedge clk)
    if (rst || (D_bubble && !D_stall)) begin
      D_stat  <= 2'd0;
      D_icode <= 4'h1;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_stat  <= stat;
      D_icode <= icode;
      D_ifun  <= ifun;
      D_rA    <= rA;
      D_rB    <= rB;
      D_valC  <= valC;
      D_valP  <= valP;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(load_d);
      perf_bubbles <= perf_bubbles + 32'(D_bubble && !D_stall);
    end
`endif
endmodule
